// File: rtl/wu_mem_arb_if.sv
// Request/command bundle between the WU fetch unit, the system loader, the
// WU memory arbiter and the WU memory port.
interface wu_mem_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  // Handshake: a requester may assert read/write (one request per cycle) and it
  // is captured on that clk edge; stall is registered, so a requester reacts one
  // cycle late and the skid FIFO absorbs that slack. Towards memory, read/write
  // are single-cycle strobes issued only when busy was 0 at the granting edge.
  logic              wuf__wua__read;
  logic [ADDR_W-1:0] wuf__wua__addr;
  logic              wua__wuf__stall;
  logic              ldr__wua__write;
  logic [ADDR_W-1:0] ldr__wua__addr;
  logic [DATA_W-1:0] ldr__wua__data;
  logic              wua__ldr__stall;
  logic              wum__wua__busy;
  logic              wua__wum__read;
  logic              wua__wum__write;
  logic [ADDR_W-1:0] wua__wum__addr;
  logic [DATA_W-1:0] wua__wum__data;
  logic              wua__sys__overflow;

  modport master (
    output wuf__wua__read, wuf__wua__addr, ldr__wua__write, ldr__wua__addr,
           ldr__wua__data, wum__wua__busy,
    input  wua__wuf__stall, wua__ldr__stall, wua__wum__read, wua__wum__write,
           wua__wum__addr, wua__wum__data, wua__sys__overflow
  );

  modport slave (
    input  wuf__wua__read, wuf__wua__addr, ldr__wua__write, ldr__wua__addr,
           ldr__wua__data, wum__wua__busy,
    output wua__wuf__stall, wua__ldr__stall, wua__wum__read, wua__wum__write,
           wua__wum__addr, wua__wum__data, wua__sys__overflow
  );
endinterface

// File: rtl/wu_mem_arb.sv
// Round-robin arbiter with burst limit sharing the single-port WU instruction
// memory between the fetch read stream and the loader write stream.
module wu_mem_arb #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int SKID_DEPTH = 4,
  parameter int MAX_BURST  = 8,
  localparam int PTR_W     = $clog2(SKID_DEPTH),
  localparam int CNT_W     = PTR_W + 1,
  localparam int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               reset_poweron,
  wu_mem_arb_if.slave        bus,
  output logic               dbg_state,
  output logic [BURST_W-1:0] dbg_burst_cnt
);

  typedef enum logic {ARB_WUF = 1'b0, ARB_LDR = 1'b1} arb_state_e;

  localparam int LW = ADDR_W + DATA_W;

  arb_state_e         state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic [ADDR_W-1:0] f_mem_q [SKID_DEPTH];
  logic [ADDR_W-1:0] f_mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]  f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [CNT_W-1:0]  f_cnt_q, f_cnt_d;

  logic [LW-1:0]     l_mem_q [SKID_DEPTH];
  logic [LW-1:0]     l_mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]  l_wr_q, l_wr_d, l_rd_q, l_rd_d;
  logic [CNT_W-1:0]  l_cnt_q, l_cnt_d;

  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              f_stall_q, f_stall_d, l_stall_q, l_stall_d;
  logic              ovf_q, ovf_d;

  logic f_ne, l_ne, f_full, l_full, f_push_ok, l_push_ok;
  logic grant_f, grant_l, burst_below;
  logic [BURST_W-1:0] burst_inc;
  logic [LW-1:0] l_head;

  assign f_ne        = (f_cnt_q != '0);
  assign l_ne        = (l_cnt_q != '0);
  assign f_full      = (f_cnt_q == CNT_W'(SKID_DEPTH));
  assign l_full      = (l_cnt_q == CNT_W'(SKID_DEPTH));
  assign burst_below = (burst_q < BURST_W'(MAX_BURST));
  assign burst_inc   = burst_below ? burst_q + BURST_W'(1) : burst_q;
  assign l_head      = l_mem_q[l_rd_q];

  // The switching grant is itself the first grant of the new owner's burst.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    grant_f = 1'b0;
    grant_l = 1'b0;
    if (!bus.wum__wua__busy) begin
      if (!f_ne && !l_ne) begin
        burst_d = '0;
      end else if (state_q == ARB_WUF) begin
        if (f_ne && (burst_below || !l_ne)) begin
          grant_f = 1'b1;
          burst_d = burst_inc;
        end else begin
          grant_l = 1'b1;
          state_d = ARB_LDR;
          burst_d = BURST_W'(1);
        end
      end else begin
        if (l_ne && (burst_below || !f_ne)) begin
          grant_l = 1'b1;
          burst_d = burst_inc;
        end else begin
          grant_f = 1'b1;
          state_d = ARB_WUF;
          burst_d = BURST_W'(1);
        end
      end
    end
  end

  // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
  assign f_push_ok = bus.wuf__wua__read  && (!f_full || grant_f);
  assign l_push_ok = bus.ldr__wua__write && (!l_full || grant_l);

  always_comb begin
    f_mem_d = f_mem_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;
    f_cnt_d = f_cnt_q;
    if (f_push_ok) begin
      f_mem_d[f_wr_q] = bus.wuf__wua__addr;
      f_wr_d          = f_wr_q + PTR_W'(1);
    end
    if (grant_f) f_rd_d = f_rd_q + PTR_W'(1);
    if (f_push_ok && !grant_f)      f_cnt_d = f_cnt_q + CNT_W'(1);
    else if (!f_push_ok && grant_f) f_cnt_d = f_cnt_q - CNT_W'(1);
  end

  always_comb begin
    l_mem_d = l_mem_q;
    l_wr_d  = l_wr_q;
    l_rd_d  = l_rd_q;
    l_cnt_d = l_cnt_q;
    if (l_push_ok) begin
      l_mem_d[l_wr_q] = {bus.ldr__wua__addr, bus.ldr__wua__data};
      l_wr_d          = l_wr_q + PTR_W'(1);
    end
    if (grant_l) l_rd_d = l_rd_q + PTR_W'(1);
    if (l_push_ok && !grant_l)      l_cnt_d = l_cnt_q + CNT_W'(1);
    else if (!l_push_ok && grant_l) l_cnt_d = l_cnt_q - CNT_W'(1);
  end

  always_comb begin
    rd_d      = grant_f;
    wr_d      = grant_l;
    addr_d    = addr_q;
    data_d    = data_q;
    if (grant_f) addr_d = f_mem_q[f_rd_q];
    if (grant_l) begin
      addr_d = l_head[LW-1:DATA_W];
      data_d = l_head[DATA_W-1:0];
    end
    f_stall_d = (f_cnt_q >= CNT_W'(SKID_DEPTH - 2));
    l_stall_d = (l_cnt_q >= CNT_W'(SKID_DEPTH - 2));
    ovf_d     = ovf_q
              | (bus.wuf__wua__read  && f_full && !grant_f)
              | (bus.ldr__wua__write && l_full && !grant_l);
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q   <= ARB_WUF;
      burst_q   <= '0;
      f_wr_q    <= '0;
      f_rd_q    <= '0;
      f_cnt_q   <= '0;
      l_wr_q    <= '0;
      l_rd_q    <= '0;
      l_cnt_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      f_stall_q <= 1'b0;
      l_stall_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      f_wr_q    <= f_wr_d;
      f_rd_q    <= f_rd_d;
      f_cnt_q   <= f_cnt_d;
      l_wr_q    <= l_wr_d;
      l_rd_q    <= l_rd_d;
      l_cnt_q   <= l_cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      f_stall_q <= f_stall_d;
      l_stall_q <= l_stall_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    f_mem_q <= f_mem_d;
    l_mem_q <= l_mem_d;
  end

  assign bus.wua__wum__read     = rd_q;
  assign bus.wua__wum__write    = wr_q;
  assign bus.wua__wum__addr     = addr_q;
  assign bus.wua__wum__data     = data_q;
  assign bus.wua__wuf__stall    = f_stall_q;
  assign bus.wua__ldr__stall    = l_stall_q;
  assign bus.wua__sys__overflow = ovf_q;
  assign dbg_state              = state_q;
  assign dbg_burst_cnt          = burst_q;

endmodule

// File: tb/tb_wu_mem_arb.sv
// Directed bench for wu_mem_arb: vector table for the cycle-exact paths plus
// scoreboarded sequences for reset, full-FIFO, back-pressure and contention.
module tb_wu_mem_arb;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int SKID_DEPTH = 4;
  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       reset_poweron;
  logic       dbg_state;
  logic [3:0] dbg_burst_cnt;

  wu_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wu_mem_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKID_DEPTH(SKID_DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .bus(bus.slave),
    .dbg_state(dbg_state),
    .dbg_burst_cnt(dbg_burst_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W-1:0]        exp_rd_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  int n_rd_seen, n_wr_seen;
  int last_kind, run_len, max_run, first_run_len, first_kind;

  typedef struct {
    logic rd; logic [ADDR_W-1:0] raddr;
    logic wr; logic [ADDR_W-1:0] waddr; logic [DATA_W-1:0] wdata;
    logic busy;
    logic e_rd; logic e_wr; logic [ADDR_W-1:0] e_addr; logic [DATA_W-1:0] e_data;
    logic e_fstall; logic e_lstall; logic e_ovf; logic e_state;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [DATA_W-1:0] wdat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  function automatic vec_t mk(input logic rd, input int raddr, input logic wr, input int waddr,
                              input logic [DATA_W-1:0] wdata, input logic busy,
                              input logic e_rd, input logic e_wr, input int e_addr,
                              input logic [DATA_W-1:0] e_data, input logic e_fstall,
                              input logic e_lstall, input logic e_ovf, input logic e_state);
    vec_t v;
    v.rd = rd; v.raddr = ADDR_W'(raddr); v.wr = wr; v.waddr = ADDR_W'(waddr);
    v.wdata = wdata; v.busy = busy; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_addr = ADDR_W'(e_addr); v.e_data = e_data; v.e_fstall = e_fstall;
    v.e_lstall = e_lstall; v.e_ovf = e_ovf; v.e_state = e_state;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [ADDR_W-1:0] raddr, input logic wr,
                       input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata,
                       input logic busy);
    bus.wuf__wua__read  = rd;
    bus.wuf__wua__addr  = raddr;
    bus.ldr__wua__write = wr;
    bus.ldr__wua__addr  = waddr;
    bus.ldr__wua__data  = wdata;
    bus.wum__wua__busy  = busy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".read"},  64'(bus.wua__wum__read), 64'd0);
    check({tag, ".write"}, 64'(bus.wua__wum__write), 64'd0);
    check({tag, ".addr"},  64'(bus.wua__wum__addr), 64'd0);
    check({tag, ".data"},  bus.wua__wum__data, 64'd0);
    check({tag, ".fstall"}, 64'(bus.wua__wuf__stall), 64'd0);
    check({tag, ".lstall"}, 64'(bus.wua__ldr__stall), 64'd0);
    check({tag, ".ovf"},   64'(bus.wua__sys__overflow), 64'd0);
    check({tag, ".state"}, 64'(dbg_state), 64'd0);
  endtask

  // Compares any memory strobe against the per-requester expected queues.
  task automatic sample_cmd(input string tag);
    logic r, w;
    int kind;
    logic [ADDR_W+DATA_W-1:0] ew;
    r = bus.wua__wum__read;
    w = bus.wua__wum__write;
    kind = 0;
    if (r || w) check({tag, ".onehot"}, 64'(r & w), 64'd0);
    if (r) begin
      kind = 1;
      n_rd_seen++;
      if (exp_rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s.unexp_read: got read addr %0h, expected no read", tag, bus.wua__wum__addr);
      end else begin
        check({tag, ".raddr"}, 64'(bus.wua__wum__addr), 64'(exp_rd_q.pop_front()));
      end
    end else if (w) begin
      kind = 2;
      n_wr_seen++;
      if (exp_wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s.unexp_write: got write addr %0h, expected no write", tag, bus.wua__wum__addr);
      end else begin
        ew = exp_wr_q.pop_front();
        check({tag, ".waddr"}, 64'(bus.wua__wum__addr), 64'(ew[ADDR_W+DATA_W-1:DATA_W]));
        check({tag, ".wdata"}, bus.wua__wum__data, ew[DATA_W-1:0]);
      end
    end
    if (kind == 0) begin
      last_kind = 0; run_len = 0;
    end else if (kind == last_kind) begin
      run_len++;
    end else begin
      if (last_kind != 0 && first_run_len == 0) begin
        first_run_len = run_len;
        first_kind = last_kind;
      end
      last_kind = kind; run_len = 1;
    end
    if (run_len > max_run) max_run = run_len;
  endtask

  task automatic reset_tracking();
    n_rd_seen = 0; n_wr_seen = 0;
    last_kind = 0; run_len = 0; max_run = 0; first_run_len = 0; first_kind = 0;
  endtask

  initial begin : main
    int pushes;
    int ra, wa;
    logic rd, wr;

    // ---------------- reset ----------------
    reset_poweron = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_poweron = 1'b1;

    // ---------------- vector table ----------------
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(1, k, 0, 0, '0, 0, (k > 0), 0, (k > 0) ? k - 1 : 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, '0, 0, 1, 0, 15, '0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, '0, 0, 0, 0, 15, '0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 1, 100 + i, wdat(i), 1, 0, 0, 15, '0, 0, (i >= 2), (i >= 4), 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, '0, 0, 0, 1, 100 + i, wdat(i), 0, (i <= 2), 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0, 0, 0, 0, 103, wdat(3), 0, 0, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].busy);
      step();
      check($sformatf("vec%0d.read", i),   64'(bus.wua__wum__read),     64'(vecs[i].e_rd));
      check($sformatf("vec%0d.write", i),  64'(bus.wua__wum__write),    64'(vecs[i].e_wr));
      check($sformatf("vec%0d.addr", i),   64'(bus.wua__wum__addr),     64'(vecs[i].e_addr));
      check($sformatf("vec%0d.data", i),   bus.wua__wum__data,          vecs[i].e_data);
      check($sformatf("vec%0d.fstall", i), 64'(bus.wua__wuf__stall),    64'(vecs[i].e_fstall));
      check($sformatf("vec%0d.lstall", i), 64'(bus.wua__ldr__stall),    64'(vecs[i].e_lstall));
      check($sformatf("vec%0d.ovf", i),    64'(bus.wua__sys__overflow), 64'(vecs[i].e_ovf));
      check($sformatf("vec%0d.state", i),  64'(dbg_state),              64'(vecs[i].e_state));
    end

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(200 + i), 1'b1, ADDR_W'(300 + i), wdat(i), 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    reset_poweron = 1'b0;
    #2;
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    reset_poweron = 1'b1;
    reset_tracking();
    repeat (4) begin
      step();
      sample_cmd("midrst_post");
    end
    check("midrst.no_strobe", 64'(n_rd_seen + n_wr_seen), 64'd0);

    // ---------------- push+pop on a full FIFO ----------------
    reset_tracking();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, ADDR_W'(400 + i), wdat(40 + i), 1'b1);
      exp_wr_q.push_back({ADDR_W'(400 + i), wdat(40 + i)});
      step();
    end
    drive(1'b0, '0, 1'b1, ADDR_W'(404), wdat(44), 1'b0);
    exp_wr_q.push_back({ADDR_W'(404), wdat(44)});
    step();
    check("fullpp.ovf", 64'(bus.wua__sys__overflow), 64'd0);
    sample_cmd("fullpp");
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (10) begin
      step();
      sample_cmd("fullpp_drain");
    end
    check("fullpp.writes", 64'(n_wr_seen), 64'd5);
    check("fullpp.left", 64'(exp_wr_q.size()), 64'd0);
    check("fullpp.ovf_end", 64'(bus.wua__sys__overflow), 64'd0);

    // ---------------- back-pressure with a stall-honoring fetch ----------------
    reset_tracking();
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      rd = !bus.wua__wuf__stall;
      drive(rd, ADDR_W'(500 + c), 1'b0, '0, '0, 1'b1);
      if (rd) begin
        exp_rd_q.push_back(ADDR_W'(500 + c));
        pushes++;
      end
      step();
      if (c == 1) check("bp.stall_c1", 64'(bus.wua__wuf__stall), 64'd0);
      if (c == 2) check("bp.stall_c2", 64'(bus.wua__wuf__stall), 64'd1);
      sample_cmd("bp_busy");
    end
    check("bp.pushes", 64'(pushes), 64'd3);
    check("bp.ovf", 64'(bus.wua__sys__overflow), 64'd0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (8) begin
      step();
      sample_cmd("bp_drain");
    end
    check("bp.reads", 64'(n_rd_seen), 64'd3);
    check("bp.left", 64'(exp_rd_q.size()), 64'd0);
    check("bp.stall_end", 64'(bus.wua__wuf__stall), 64'd0);

    // ---------------- contention, both honoring stall ----------------
    reset_tracking();
    ra = 600;
    wa = 700;
    for (int c = 0; c < 60; c++) begin
      rd = !bus.wua__wuf__stall;
      wr = !bus.wua__ldr__stall;
      drive(rd, ADDR_W'(ra), wr, ADDR_W'(wa), wdat(wa), 1'b0);
      if (rd) begin exp_rd_q.push_back(ADDR_W'(ra)); ra++; end
      if (wr) begin exp_wr_q.push_back({ADDR_W'(wa), wdat(wa)}); wa++; end
      step();
      sample_cmd("cont");
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (20) begin
      step();
      sample_cmd("cont_drain");
    end
    check("cont.first_kind", 64'(first_kind), 64'd1);
    check("cont.first_run", 64'(first_run_len), 64'(MAX_BURST));
    check("cont.max_run_le", 64'(max_run <= MAX_BURST), 64'd1);
    check("cont.rd_left", 64'(exp_rd_q.size()), 64'd0);
    check("cont.wr_left", 64'(exp_wr_q.size()), 64'd0);
    check("cont.rd_count", 64'(n_rd_seen), 64'(ra - 600));
    check("cont.wr_count", 64'(n_wr_seen), 64'(wa - 700));
    check("cont.ovf", 64'(bus.wua__sys__overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
